ftoi_arbiter: RTL and testbench

- Shares one float-to-int conversion datapath between two requesters: port 0 is the FPU issue path, port 1 is the auxiliary/IO path.
- Round-robin arbitration on valid/ready handshakes.
- Two-stage pipeline: operand register, then result register after conversion.
- Sits between the FPU dispatch stage and the writeback mux. Keeps a sticky overflow flag for the FCSR.

---
 rtl/ftoi_arbiter.sv | 120 ++++++++++++
 tb/tb_ftoi_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ftoi_arbiter.sv
// Two-requester round-robin front end for a shared float-to-int converter.
// Stage 1 holds the granted operand, stage 2 holds the converted result.
module ftoi_arbiter #(
  parameter int TAG_W    = 5,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_x,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_x,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_y,
  output logic             resp_ovf,
  output logic             resp_src,
  output logic [TAG_W-1:0] resp_tag,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  logic             last_gnt;
  logic             s1_valid;
  logic             s1_src;
  logic [31:0]      s1_x;
  logic [TAG_W-1:0] s1_tag;

  logic adv2, acc1, gnt0, gnt1, xfer0, xfer1;
  logic [7:0]  e;
  logic [23:0] mant;
  logic [31:0] mag;
  logic [31:0] conv_y;
  logic        conv_ovf;

  // Grant goes to the requester that did not win last time when both ask.
  always_comb begin
    adv2  = !resp_valid || resp_ready;
    acc1  = !s1_valid || adv2;
    gnt0  = req0_valid && (!req1_valid || last_gnt);
    gnt1  = req1_valid && (!req0_valid || !last_gnt);
    xfer0 = gnt0 && acc1;
    xfer1 = gnt1 && acc1;
  end

  assign req0_ready = xfer0;
  assign req1_ready = xfer1;

  // Round to nearest, ties away from zero: add the first bit shifted out.
  always_comb begin
    e        = s1_x[30:23];
    mant     = {1'b1, s1_x[22:0]};
    mag      = '0;
    conv_ovf = 1'b0;
    if (e <= 8'd125) begin
      mag = '0;
    end else if (e == 8'd126) begin
      mag = 32'd1;
    end else if (e <= 8'd149) begin
      mag = {8'd0, mant >> (8'd150 - e)} + {31'd0, mant[5'(8'd149 - e)]};
    end else begin
      mag      = {8'd0, mant} << (e - 8'd150);
      conv_ovf = (e >= 8'd158);
    end
    conv_y = s1_x[31] ? -mag : mag;
    if (conv_ovf && SATURATE != 0) begin
      conv_y = s1_x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_src     <= 1'b0;
      s1_x       <= '0;
      s1_tag     <= '0;
      last_gnt   <= 1'b1;
      resp_valid <= 1'b0;
      resp_y     <= '0;
      resp_ovf   <= 1'b0;
      resp_src   <= 1'b0;
      resp_tag   <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (acc1) begin
        s1_valid <= xfer0 || xfer1;
        if (xfer1) begin
          s1_x   <= req1_x;
          s1_tag <= req1_tag;
          s1_src <= 1'b1;
        end else if (xfer0) begin
          s1_x   <= req0_x;
          s1_tag <= req0_tag;
          s1_src <= 1'b0;
        end
      end
      if (xfer0) last_gnt <= 1'b0;
      else if (xfer1) last_gnt <= 1'b1;

      if (adv2) begin
        resp_valid <= s1_valid;
        if (s1_valid) begin
          resp_y   <= conv_y;
          resp_ovf <= conv_ovf;
          resp_src <= s1_src;
          resp_tag <= s1_tag;
        end
      end

      // A handoff of an overflowed result beats a same-cycle clear.
      if (resp_valid && resp_ready && resp_ovf) ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ftoi_arbiter.sv
// Directed and randomized checks of ftoi_arbiter against a scoreboard whose
// expected results come from real-number rounding of the IEEE operand.
module tb_ftoi_arbiter;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 0, req1_valid = 0;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_x = 0, req1_x = 0;
  logic [TAG_W-1:0] req0_tag = 0, req1_tag = 0;
  logic             resp_valid, resp_ready = 1'b1;
  logic [31:0]      resp_y;
  logic             resp_ovf, resp_src;
  logic [TAG_W-1:0] resp_tag;
  logic             ovf_sticky, ovf_clr = 1'b0;

  ftoi_arbiter #(.TAG_W(TAG_W), .SATURATE(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_tag(req1_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y), .resp_ovf(resp_ovf),
    .resp_src(resp_src), .resp_tag(resp_tag), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      y;
    logic             ovf;
    logic             src;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];
  logic glog[$];
  int   tests = 0, fails = 0;
  logic m_last = 1'b1, m_sticky = 1'b0;
  logic xfer0, xfer1, hs;
  logic [31:0] last_hs_y;
  int   hs_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact real value of the operand, rounded half away from zero.
  function automatic logic [31:0] model_y(input logic [31:0] x, output logic ovf);
    int     ex = int'(x[30:23]);
    real    v;
    longint mag;
    ovf = (ex >= 158);
    if (ovf) return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    v = real'(int'({1'b1, x[22:0]}));
    if (ex >= 150) for (int i = 0; i < ex - 150; i++) v = v * 2.0;
    else           for (int i = 0; i < 150 - ex; i++) v = v / 2.0;
    mag = longint'($rtoi(v + 0.5));
    return x[31] ? 32'(-mag) : 32'(mag);
  endfunction

  task automatic step();
    exp_t e;
    @(negedge clk);
    xfer0 = req0_valid && req0_ready;
    xfer1 = req1_valid && req1_ready;
    hs    = resp_valid && resp_ready;
    chk("one_ready", {31'd0, req0_ready && req1_ready}, 32'd0);
    chk("sticky", {31'd0, ovf_sticky}, {31'd0, m_sticky});
    if (resp_valid) begin
      if (q.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
      else begin
        chk("resp_y", resp_y, q[0].y);
        chk("resp_ovf", {31'd0, resp_ovf}, {31'd0, q[0].ovf});
        chk("resp_src", {31'd0, resp_src}, {31'd0, q[0].src});
        chk("resp_tag", 32'(resp_tag), 32'(q[0].tag));
      end
    end
    if (rst) begin
      q.delete();
      m_last   = 1'b1;
      m_sticky = 1'b0;
    end else begin
      if (hs && q.size() > 0) begin
        e = q.pop_front();
        last_hs_y = resp_y;
        hs_cnt++;
        if (e.ovf) m_sticky = 1'b1;
        else if (ovf_clr) m_sticky = 1'b0;
      end else if (ovf_clr) m_sticky = 1'b0;
      if (xfer0 || xfer1) begin
        if (req0_valid && req1_valid) chk("rr_grant", {31'd0, xfer1}, {31'd0, !m_last});
        m_last = xfer1;
        e.y   = model_y(xfer1 ? req1_x : req0_x, e.ovf);
        e.src = xfer1;
        e.tag = xfer1 ? req1_tag : req0_tag;
        q.push_back(e);
        glog.push_back(xfer1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic p, input logic [31:0] x, input logic [TAG_W-1:0] tag,
                          input logic [31:0] exp_y);
    int n0;
    bit got;
    n0 = hs_cnt;
    got = 0;
    if (p) begin req1_valid = 1; req1_x = x; req1_tag = tag; end
    else   begin req0_valid = 1; req0_x = x; req0_tag = tag; end
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = p ? xfer1 : xfer0;
    end
    req0_valid = 0; req1_valid = 0;
    if (!got) chk("send_timeout", 32'd1, 32'd0);
    for (int i = 0; i < 20 && hs_cnt == n0; i++) step();
    if (hs_cnt == n0) chk("resp_timeout", 32'd1, 32'd0);
    else chk("dir_y", last_hs_y, exp_y);
  endtask

  function automatic logic [31:0] rand_x();
    logic [7:0] ex;
    logic [22:0] m;
    ex = ($urandom % 16 == 0) ? 8'd255 : 8'($urandom_range(100, 170));
    m  = 23'($urandom);
    if ($urandom % 3 == 0) m = m & 23'h7F0000;
    return {1'($urandom), ex, m};
  endfunction

  initial begin
    int n;
    step(); step();
    rst = 0;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_y", resp_y, 32'd0);
    chk("rst_resp_ovf", {31'd0, resp_ovf}, 32'd0);
    chk("rst_resp_src", {31'd0, resp_src}, 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    chk("rst_sticky", {31'd0, ovf_sticky}, 32'd0);

    // Single op with latency
    req0_valid = 1; req0_x = 32'h3F80_0000; req0_tag = 5'd3;
    step();
    chk("lat_xfer", {31'd0, xfer0}, 32'd1);
    req0_valid = 0;
    chk("lat_n", {31'd0, resp_valid}, 32'd0);
    step();
    chk("lat_n1", {31'd0, resp_valid}, 32'd1);
    chk("lat_y", resp_y, 32'd1);
    chk("lat_tag", 32'(resp_tag), 32'd3);
    step();

    // Rounding on requester 1
    send_one(1'b1, 32'h4020_0000, 5'd1, 32'd3);
    send_one(1'b1, 32'hBFC0_0000, 5'd2, 32'hFFFF_FFFE);
    send_one(1'b1, 32'h3F00_0000, 5'd4, 32'd1);
    send_one(1'b1, 32'h3ECC_CCCD, 5'd5, 32'd0);

    // Alternating grants under a tie
    glog.delete();
    req0_valid = 1; req1_valid = 1; req0_x = 32'h4100_0000; req1_x = 32'hC100_0000;
    req0_tag = 5'd10; req1_tag = 5'd20;
    for (int i = 0; i < 6; i++) begin
      step();
      if (xfer0) req0_tag = req0_tag + 5'd1;
      if (xfer1) req1_tag = req1_tag + 5'd1;
    end
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 4; i++) step();
    chk("rr_count", 32'(glog.size()), 32'd6);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      chk("rr_order", {31'd0, glog[i]}, 32'(i % 2));

    // Overflow and sticky flag
    send_one(1'b0, 32'h4F00_0000, 5'd7, 32'h7FFF_FFFF);
    step();
    chk("sticky_set", {31'd0, ovf_sticky}, 32'd1);
    send_one(1'b0, 32'hCF80_0000, 5'd8, 32'h8000_0000);
    ovf_clr = 1;
    send_one(1'b1, 32'h7F80_0000, 5'd9, 32'h7FFF_FFFF);
    ovf_clr = 0;
    step();
    chk("sticky_set_wins", {31'd0, ovf_sticky}, 32'd1);
    ovf_clr = 1; step(); ovf_clr = 0; step();
    chk("sticky_clr", {31'd0, ovf_sticky}, 32'd0);

    // Backpressure
    resp_ready = 0;
    req0_valid = 1; req0_x = 32'h4020_0000; req0_tag = 5'd1;
    step(); req0_valid = 0;
    step(); step();
    n = 0;
    req0_valid = 1; req1_valid = 1; req0_x = 32'h4040_0000; req1_x = 32'h4080_0000;
    for (int i = 0; i < 4; i++) begin
      step();
      if (xfer0 || xfer1) n++;
    end
    chk("bp_accepts", 32'(n), 32'd1);
    chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
    chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
    req0_valid = 0; req1_valid = 0; resp_ready = 1;
    n = hs_cnt;
    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    chk("bp_drain", 32'(q.size()), 32'd0);
    chk("bp_count", 32'(hs_cnt - n), 32'd2);

    // Reset with both stages full
    send_one(1'b0, 32'h5000_0000, 5'd11, 32'h7FFF_FFFF);
    step();
    resp_ready = 0;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 3; i++) step();
    req0_valid = 0; req1_valid = 0;
    rst = 1; step(); rst = 0;
    chk("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mid_sticky", {31'd0, ovf_sticky}, 32'd0);
    resp_ready = 1; req0_valid = 1; req1_valid = 1; req0_tag = 5'd1; req1_tag = 5'd2;
    step();
    chk("rst_tie_req0", {30'd0, xfer1, xfer0}, 32'd1);
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid || xfer0) begin
        req0_valid = ($urandom % 3) != 0; req0_x = rand_x(); req0_tag = TAG_W'($urandom);
      end
      if (!req1_valid || xfer1) begin
        req1_valid = ($urandom % 3) != 0; req1_x = rand_x(); req1_tag = TAG_W'($urandom);
      end
      resp_ready = ($urandom % 4) != 0;
      ovf_clr    = ($urandom % 8) == 0;
      step();
    end
    req0_valid = 0; req1_valid = 0; resp_ready = 1; ovf_clr = 0;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    chk("final_drain", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
